// File: rtl/fpu_req_arbiter.sv
// Round-robin arbiter sharing one FPU core among four requesters.
// Each accepted op runs ISSUE -> WAIT -> RESP; a stalled core is aborted with a quiet NaN.
module fpu_req_arbiter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [7:0]   req_op,
  input  logic [127:0] req_a,
  input  logic [127:0] req_b,
  output logic         fpu_start,
  output logic [1:0]   fpu_op,
  output logic [31:0]  fpu_a,
  output logic [31:0]  fpu_b,
  input  logic         fpu_done,
  input  logic [31:0]  fpu_result,
  output logic [3:0]   rsp_valid,
  input  logic [3:0]   rsp_ready,
  output logic [31:0]  rsp_result,
  output logic         rsp_timeout,
  output logic         busy
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ISSUE  = 2'd1;
  localparam logic [1:0]  S_WAIT   = 2'd2;
  localparam logic [1:0]  S_RESP   = 2'd3;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [7:0]  TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  r_state;
  logic [1:0]  r_last_grant;
  logic [1:0]  r_owner;
  logic [7:0]  r_cnt;
  logic [1:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;
  logic        r_timeout;

  logic [2:0]  w_pick;
  logic        w_grant_vld;
  logic [1:0]  w_grant_idx;
  logic        w_grant;

  // Returns {found, index}; offsets are scanned high to low so the nearest one after 'last' wins.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] last);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (valid[idx]) begin
        pick = {1'b1, idx};
      end
    end
    return pick;
  endfunction

  assign w_pick      = rr_pick(req_valid, r_last_grant);
  assign w_grant_vld = w_pick[2];
  assign w_grant_idx = w_pick[1:0];
  assign w_grant     = !reset && (r_state == S_IDLE) && w_grant_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= 2'd3;
      r_owner      <= 2'd0;
      r_cnt        <= 8'd0;
      r_op         <= 2'd0;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_result     <= 32'd0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_op         <= req_op[{w_grant_idx, 1'b0} +: 2];
            r_a          <= req_a[{w_grant_idx, 5'b00000} +: 32];
            r_b          <= req_b[{w_grant_idx, 5'b00000} +: 32];
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A completion on the final allowed cycle still beats the abort.
          if (fpu_done) begin
            r_result  <= fpu_result;
            r_timeout <= 1'b0;
            r_state   <= S_RESP;
          end else if (r_cnt == TMO_LAST) begin
            r_result  <= QNAN;
            r_timeout <= 1'b1;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_owner]) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    req_ready   = 4'b0000;
    fpu_start   = 1'b0;
    fpu_op      = 2'd0;
    fpu_a       = 32'd0;
    fpu_b       = 32'd0;
    rsp_valid   = 4'b0000;
    rsp_result  = 32'd0;
    rsp_timeout = 1'b0;
    busy        = 1'b0;
    if (!reset) begin
      if (w_grant) begin
        req_ready = 4'b0001 << w_grant_idx;
      end else begin
        req_ready = 4'b0000;
      end
      fpu_start  = (r_state == S_ISSUE);
      fpu_op     = r_op;
      fpu_a      = r_a;
      fpu_b      = r_b;
      rsp_result = r_result;
      busy       = (r_state != S_IDLE);
      if (r_state == S_RESP) begin
        rsp_valid   = 4'b0001 << r_owner;
        rsp_timeout = r_timeout;
      end else begin
        rsp_valid   = 4'b0000;
        rsp_timeout = 1'b0;
      end
    end else begin
      busy = 1'b0;
    end
  end

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed bench for fpu_req_arbiter with hand-computed expectations.
module tb_fpu_req_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = 4'b0000;
  logic [3:0]   req_ready;
  logic [7:0]   req_op = 8'h00;
  logic [127:0] req_a = 128'd0;
  logic [127:0] req_b = 128'd0;
  logic         fpu_start;
  logic [1:0]   fpu_op;
  logic [31:0]  fpu_a;
  logic [31:0]  fpu_b;
  logic         fpu_done = 1'b0;
  logic [31:0]  fpu_result = 32'd0;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready = 4'b0000;
  logic [31:0]  rsp_result;
  logic         rsp_timeout;
  logic         busy;

  int total = 0;
  int bad = 0;

  fpu_req_arbiter #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .fpu_start(fpu_start),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 4'b1111;
    tick();
    tick();
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%b want=0000", req_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (fpu_start !== 1'b0) begin bad++; $display("FAIL rst_fpu_start got=%b want=0", fpu_start); end
    total++; if ({fpu_op, fpu_a, fpu_b} !== 66'd0) begin bad++; $display("FAIL rst_fpu_bus got=%h want=0", {fpu_op, fpu_a, fpu_b}); end
    total++; if ({rsp_valid, rsp_result, rsp_timeout} !== 37'd0) begin bad++; $display("FAIL rst_rsp got=%h want=0", {rsp_valid, rsp_result, rsp_timeout}); end
    req_valid = 4'b0000;
    reset = 1'b0;
    tick();
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
  endtask

  task automatic test_single();
    int starts;
    starts = 0;
    req_valid = 4'b0001;
    req_op[1:0] = 2'b00;
    req_a[31:0] = 32'h3F80_0000;
    req_b[31:0] = 32'h4000_0000;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    #1;
    starts += int'(fpu_start);
    total++; if ({fpu_op, fpu_a, fpu_b} !== {2'b00, 32'h3F80_0000, 32'h4000_0000}) begin bad++; $display("FAIL single_operands got=%h want=%h", {fpu_op, fpu_a, fpu_b}, {2'b00, 32'h3F80_0000, 32'h4000_0000}); end
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      starts += int'(fpu_start);
      tick();
    end
    fpu_done = 1'b1;
    fpu_result = 32'h4040_0000;
    #1;
    starts += int'(fpu_start);
    tick();
    fpu_done = 1'b0;
    #1;
    total++; if (rsp_valid !== 4'b0001) begin bad++; $display("FAIL single_rsp_valid got=%b want=0001", rsp_valid); end
    total++; if (rsp_result !== 32'h4040_0000) begin bad++; $display("FAIL single_rsp_result got=%h want=40400000", rsp_result); end
    total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL single_rsp_timeout got=%b want=0", rsp_timeout); end
    total++; if (starts != 1) begin bad++; $display("FAIL single_start_count got=%0d want=1", starts); end
    rsp_ready = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp = 4'b0001 << (k % 4);
      #1;
      total++; if (req_ready !== exp) begin bad++; $display("FAIL rr_grant%0d got=%b want=%b", k, req_ready, exp); end
      tick();
      tick();
      fpu_done = 1'b1;
      fpu_result = 32'h1000_0000 + 32'(k);
      tick();
      fpu_done = 1'b0;
      rsp_ready = 4'b1111;
      #1;
      total++; if (rsp_valid !== exp) begin bad++; $display("FAIL rr_rsp%0d got=%b want=%b", k, rsp_valid, exp); end
      total++; if (rsp_result !== 32'h1000_0000 + 32'(k)) begin bad++; $display("FAIL rr_result%0d got=%h want=%h", k, rsp_result, 32'h1000_0000 + 32'(k)); end
      tick();
      rsp_ready = 4'b0000;
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    for (int w = 1; w <= 64; w++) begin
      #1;
      if (rsp_valid !== 4'b0000) early = 1'b1;
      tick();
    end
    total++; if (early !== 1'b0) begin bad++; $display("FAIL tmo_early_rsp got=%b want=0", early); end
    #1;
    total++; if (rsp_valid !== 4'b0010) begin bad++; $display("FAIL tmo_rsp_valid got=%b want=0010", rsp_valid); end
    total++; if (rsp_result !== 32'h7FC0_0000) begin bad++; $display("FAIL tmo_result got=%h want=7fc00000", rsp_result); end
    total++; if (rsp_timeout !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b want=1", rsp_timeout); end
    rsp_ready = 4'b0010;
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_done_at_timeout();
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0000;
    tick();
    for (int w = 1; w <= 63; w++) tick();
    fpu_done = 1'b1;
    fpu_result = 32'h4120_0000;
    tick();
    fpu_done = 1'b0;
    #1;
    total++; if (rsp_valid !== 4'b0100) begin bad++; $display("FAIL edge_rsp_valid got=%b want=0100", rsp_valid); end
    total++; if (rsp_result !== 32'h4120_0000) begin bad++; $display("FAIL edge_result got=%h want=41200000", rsp_result); end
    total++; if (rsp_timeout !== 1'b0) begin bad++; $display("FAIL edge_flag got=%b want=0", rsp_timeout); end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_back_pressure();
    req_valid = 4'b1000;
    tick();
    tick();
    fpu_done = 1'b1;
    fpu_result = 32'h3F00_0000;
    tick();
    fpu_done = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 4'b0111;
    for (int c = 0; c < 10; c++) begin
      #1;
      total++; if (rsp_valid !== 4'b1000 || rsp_result !== 32'h3F00_0000) begin bad++; $display("FAIL bp_hold%0d got=%b/%h want=1000/3f000000", c, rsp_valid, rsp_result); end
      total++; if (req_ready !== 4'b0000 || fpu_start !== 1'b0) begin bad++; $display("FAIL bp_quiet%0d got=%b/%b want=0000/0", c, req_ready, fpu_start); end
      tick();
    end
    rsp_ready = 4'b1000;
    #1;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_exit_ready got=%b want=0000", req_ready); end
    tick();
    rsp_ready = 4'b0000;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_next_grant got=%b want=0001", req_ready); end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_op();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    #1;
    total++; if ({busy, rsp_valid, req_ready, fpu_start} !== 10'd0) begin bad++; $display("FAIL mid_rst_outputs got=%b want=0", {busy, rsp_valid, req_ready, fpu_start}); end
    tick();
    reset = 1'b0;
    fpu_done = 1'b1;
    fpu_result = 32'h1234_5678;
    tick();
    fpu_done = 1'b0;
    #1;
    total++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin bad++; $display("FAIL late_done got=%b/%b want=0000/0", rsp_valid, busy); end
    total++; if ({fpu_a, rsp_result} !== 64'd0) begin bad++; $display("FAIL mid_rst_data got=%h want=0", {fpu_a, rsp_result}); end
    req_valid = 4'b1111;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_rst_regrant got=%b want=0001", req_ready); end
    req_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_at_timeout();
    test_back_pressure();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
